// File: rtl/muxn_sel_reg.sv
// muxn_sel_reg: N-channel registered mux with latched select, source-tagged output and round-robin auto scan
module muxn_sel_reg #(
    parameter int WIDTH = 8,
    parameter int NCH = 4,
    parameter int DWELL = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [SELW-1:0]        sel_in,
    input  logic                   sel_load,
    input  logic                   auto_en,
    output logic [WIDTH-1:0]       out,
    output logic [SELW-1:0]        out_ch,
    output logic                   out_valid,
    output logic [SELW-1:0]        cur_sel,
    output logic                   sel_err
);
    localparam int CW = $clog2(DWELL + 1);

    logic [WIDTH-1:0] out_d, out_q;
    logic [SELW-1:0]  out_ch_d, out_ch_q, cur_sel_d, cur_sel_q;
    logic [CW-1:0]    cnt_d, cnt_q;
    logic             out_valid_d, out_valid_q, run_d, run_q;
    logic             sel_err_d, sel_err_q, auto_d, auto_q;
    logic             load_ok, load_bad, expire;

    // auto_q lags auto_en so the first auto edge only clears the dwell counter
    always_comb begin
        load_ok     = sel_load && (int'(sel_in) < NCH);
        load_bad    = sel_load && !load_ok;
        expire      = auto_en && auto_q && !load_bad && (cnt_q == CW'(DWELL - 1));
        cur_sel_d   = load_ok ? sel_in :
                      expire  ? ((cur_sel_q == SELW'(NCH - 1)) ? '0 : cur_sel_q + 1'b1) :
                      cur_sel_q;
        cnt_d       = (!auto_en || !auto_q || load_ok || expire) ? '0 :
                      load_bad ? cnt_q : cnt_q + 1'b1;
        out_d       = in_data[int'(cur_sel_q)*WIDTH +: WIDTH];
        out_ch_d    = cur_sel_q;
        run_d       = 1'b1;
        out_valid_d = run_q;
        sel_err_d   = load_bad;
        auto_d      = auto_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_ch_q    <= '0;
            cur_sel_q   <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            run_q       <= 1'b0;
            sel_err_q   <= 1'b0;
            auto_q      <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            cur_sel_q   <= cur_sel_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            run_q       <= run_d;
            sel_err_q   <= sel_err_d;
            auto_q      <= auto_d;
        end
    end

    assign out       = out_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign cur_sel   = cur_sel_q;
    assign sel_err   = sel_err_q;
endmodule

// File: tb/tb_muxn_sel_reg.sv
// tb_muxn_sel_reg: randomized and directed checks of two muxn_sel_reg instances (NCH=4 and NCH=3) against a dwell-countdown model
module tb_muxn_sel_reg;
    localparam int W = 8;
    localparam int DW = 3;

    logic        clk = 0;
    logic        rst_n = 1;
    logic        sel_load = 0;
    logic        auto_en = 0;
    logic [1:0]  sel_in = 0;
    logic [31:0] in_data = 0;
    logic [7:0]  out_a, out_b;
    logic [1:0]  ch_a, ch_b, cs_a, cs_b;
    logic        v_a, v_b, e_a, e_b;

    muxn_sel_reg #(.WIDTH(W), .NCH(4), .DWELL(DW)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel_in(sel_in),
        .sel_load(sel_load), .auto_en(auto_en), .out(out_a), .out_ch(ch_a),
        .out_valid(v_a), .cur_sel(cs_a), .sel_err(e_a)
    );

    muxn_sel_reg #(.WIDTH(W), .NCH(3), .DWELL(DW)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[23:0]), .sel_in(sel_in),
        .sel_load(sel_load), .auto_en(auto_en), .out(out_b), .out_ch(ch_b),
        .out_valid(v_b), .cur_sel(cs_b), .sel_err(e_b)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int nch[2] = '{4, 3};
    int m_sel[2], m_left[2], x_out[2], x_ch[2], x_val[2], x_err[2];
    int m_run, m_prev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int d = 0; d < 2; d++) begin
            m_sel[d] = 0; m_left[d] = DW;
            x_out[d] = 0; x_ch[d] = 0; x_val[d] = 0; x_err[d] = 0;
        end
        m_run = 0;
        m_prev = 0;
    endfunction

    // m_left = edges remaining on the current channel before the scan moves on
    function automatic void m_edge();
        for (int d = 0; d < 2; d++) begin
            x_out[d] = int'((in_data >> (m_sel[d] * W)) & 32'hFF);
            x_ch[d]  = m_sel[d];
            x_val[d] = m_run;
            x_err[d] = (sel_load && int'(sel_in) >= nch[d]) ? 1 : 0;
            if (sel_load && int'(sel_in) < nch[d]) begin
                m_sel[d] = int'(sel_in); m_left[d] = DW;
            end else if (sel_load) begin
            end else if (!auto_en || m_prev == 0) begin
                m_left[d] = DW;
            end else if (m_left[d] == 1) begin
                m_sel[d] = (m_sel[d] + 1) % nch[d]; m_left[d] = DW;
            end else begin
                m_left[d]--;
            end
        end
        m_run = 1;
        m_prev = auto_en ? 1 : 0;
    endfunction

    task automatic check_all();
        chk("out_a", 32'(out_a), x_out[0]);
        chk("ch_a", 32'(ch_a), x_ch[0]);
        chk("valid_a", 32'(v_a), x_val[0]);
        chk("err_a", 32'(e_a), x_err[0]);
        chk("sel_a", 32'(cs_a), m_sel[0]);
        chk("out_b", 32'(out_b), x_out[1]);
        chk("ch_b", 32'(ch_b), x_ch[1]);
        chk("valid_b", 32'(v_b), x_val[1]);
        chk("err_b", 32'(e_b), x_err[1]);
        chk("sel_b", 32'(cs_b), m_sel[1]);
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
        check_all();
    endtask

    int exp_seq[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    int prev_b;
    bit found;

    initial begin
        m_reset();
        #1 rst_n = 0;
        #1 check_all();
        rst_n = 1;
        step();
        chk("valid_edge0", 32'(v_a), 0);
        in_data = 32'h44332211;
        step();
        chk("valid_edge1", 32'(v_a), 1);

        sel_in = 2; sel_load = 1;
        step();
        sel_load = 0;
        chk("man_sel_t", 32'(cs_a), 2);
        chk("man_out_t", 32'(out_a), 32'h11);
        chk("man_ch_t", 32'(ch_a), 0);
        step();
        chk("man_out_t1", 32'(out_a), 32'h33);
        chk("man_ch_t1", 32'(ch_a), 2);

        sel_in = 0; sel_load = 1;
        step();
        sel_load = 0;
        auto_en = 1;
        for (int i = 0; i < 13; i++) begin
            step();
            chk($sformatf("scan%0d", i), 32'(cs_a), exp_seq[i]);
        end

        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_sel[0] == 2 && m_left[0] == 1) found = 1;
            else step();
        end
        chk("find_expiry", 32'(found), 1);
        sel_in = 1; sel_load = 1;
        step();
        sel_load = 0;
        chk("lvx_0", 32'(cs_a), 1);
        step();
        chk("lvx_1", 32'(cs_a), 1);
        step();
        chk("lvx_2", 32'(cs_a), 1);
        step();
        chk("lvx_adv", 32'(cs_a), 2);

        auto_en = 0;
        step();
        prev_b = int'(cs_b);
        sel_in = 3; sel_load = 1;
        step();
        chk("inv_sel_b", 32'(cs_b), prev_b);
        chk("inv_err_b", 32'(e_b), 1);
        chk("inv_err_a", 32'(e_a), 0);
        sel_in = 0;
        step();
        sel_load = 0;
        chk("inv_fix_sel_b", 32'(cs_b), 0);
        chk("inv_fix_err_b", 32'(e_b), 0);
        step();

        auto_en = 1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (cs_a == 2) found = 1;
            else step();
        end
        chk("find_ch2", 32'(found), 1);
        auto_en = 0;
        for (int i = 0; i < 8; i++) begin
            in_data = $urandom;
            step();
            chk("exit_hold", 32'(cs_a), 2);
        end

        auto_en = 1;
        for (int i = 0; i < 5; i++) step();
        rst_n = 0;
        m_reset();
        #1 check_all();
        rst_n = 1;
        for (int i = 0; i < 8; i++) step();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) auto_en = ~auto_en;
            sel_load = ($urandom_range(0, 4) == 0);
            sel_in = 2'($urandom);
            in_data = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
